// File: rtl/rv32i_register.sv
// Integer register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits with x0
// hardwired to zero, two combinational read ports and one synchronous write
// port. An optional write-through bypass lets a value being written this
// cycle appear on a read port that addresses the same register.
//
// Note: rst_n is an active-HIGH synchronous reset despite its suffix.
module rv32i_register #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter bit WRITE_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_we
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // x0 has no storage; the array covers x1..x(NUM_REGS-1) only.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // A write is effective only outside reset and never to x0. The same
    // qualifier gates the bypass, so forwarded data always equals what the
    // array will hold after the edge.
    logic wr_en;
    assign wr_en = rd_we && !rst_n && (rd_addr != '0);

    // Next-state of the array: reset clears everything and wins over a write.
    always_comb begin
        regs_d = regs_q;
        if (rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && (rd_addr == ADDR_WIDTH'(i))) begin
                    regs_d[i] = rd_data;
                end
            end
        end
    end

    // Register array state update.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Stored-value lookup for both ports; address 0 falls through to zero.
    logic [DATA_WIDTH-1:0] rs1_stored;
    logic [DATA_WIDTH-1:0] rs2_stored;

    // Array read mux for both ports.
    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == ADDR_WIDTH'(i)) begin
                rs1_stored = regs_q[i];
            end
            if (rs2_addr == ADDR_WIDTH'(i)) begin
                rs2_stored = regs_q[i];
            end
        end
    end

    // Output select: each port independently takes the write data when it
    // addresses the register being written (bypass enabled), else the array.
    // wr_en already excludes x0 and reset, so address 0 stays zero.
    always_comb begin
        rs1_data = rs1_stored;
        rs2_data = rs2_stored;
        if (WRITE_BYPASS) begin
            if (wr_en && (rs1_addr == rd_addr)) begin
                rs1_data = rd_data;
            end
            if (wr_en && (rs2_addr == rd_addr)) begin
                rs2_data = rd_data;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_register.sv
// Directed testbench for rv32i_register (default parameters, bypass enabled).
module tb_rv32i_register;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;

    int tests;
    int fails;

    rv32i_register dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_we    (rd_we)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // one-edge register write
    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        rd_we   = 1'b1;
        rd_addr = a;
        rd_data = d;
        tick();
        rd_we   = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b1;
        rd_we    = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        tick();
        tick();
        rst_n = 1'b0;

        // reset state: every address reads zero on both ports
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 4'(i);
            rs2_addr = 4'(15 - i);
            #1;
            check("reset_rs1", rs1_data, 32'h0);
            check("reset_rs2", rs2_data, 32'h0);
        end

        // reset clears a written register
        write_reg(4'd5, 32'hDEADBEEF);
        rs1_addr = 4'd5;
        #1;
        check("x5_written", rs1_data, 32'hDEADBEEF);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("x5_after_reset", rs1_data, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rs2_addr = 4'(i);
            #1;
            check("all_zero_after_reset", rs2_data, 32'h0);
        end

        // basic write/read
        write_reg(4'd1, 32'h12345678);
        write_reg(4'd15, 32'hFFFFFFFF);
        rs1_addr = 4'd1;
        rs2_addr = 4'd15;
        #1;
        check("x1_read", rs1_data, 32'h12345678);
        check("x15_read", rs2_data, 32'hFFFFFFFF);

        // x0 immutability, including during the write cycle
        rd_we    = 1'b1;
        rd_addr  = 4'd0;
        rd_data  = 32'hA5A5A5A5;
        rs1_addr = 4'd0;
        rs2_addr = 4'd0;
        #1;
        check("x0_during_write_rs1", rs1_data, 32'h0);
        check("x0_during_write_rs2", rs2_data, 32'h0);
        tick();
        rd_we = 1'b0;
        #1;
        check("x0_after_write_rs1", rs1_data, 32'h0);
        check("x0_after_write_rs2", rs2_data, 32'h0);

        // write enable gating
        write_reg(4'd3, 32'h11111111);
        rd_we   = 1'b0;
        rd_addr = 4'd3;
        rd_data = 32'h22222222;
        rs1_addr = 4'd3;
        #1;
        check("x3_no_bypass_we0", rs1_data, 32'h11111111);
        tick();
        check("x3_gated", rs1_data, 32'h11111111);

        // same-cycle bypass on both ports
        rs1_addr = 4'd7;
        rs2_addr = 4'd7;
        rd_we    = 1'b1;
        rd_addr  = 4'd7;
        rd_data  = 32'hCAFEBABE;
        #1;
        check("bypass_rs1", rs1_data, 32'hCAFEBABE);
        check("bypass_rs2", rs2_data, 32'hCAFEBABE);
        tick();
        rd_we   = 1'b0;
        rd_data = 32'h0;
        #1;
        check("stored_rs1_x7", rs1_data, 32'hCAFEBABE);
        check("stored_rs2_x7", rs2_data, 32'hCAFEBABE);

        // independent bypass: only the matching port forwards
        write_reg(4'd2, 32'h00000001);
        rd_we    = 1'b1;
        rd_addr  = 4'd2;
        rd_data  = 32'h00000002;
        rs1_addr = 4'd2;
        rs2_addr = 4'd7;
        #1;
        check("bypass_rs1_only", rs1_data, 32'h00000002);
        check("no_bypass_rs2", rs2_data, 32'hCAFEBABE);
        tick();
        rd_we = 1'b0;
        #1;
        check("x2_stored", rs1_data, 32'h00000002);

        // reset vs write collision; bypass disabled during reset
        write_reg(4'd4, 32'h0F0F0F0F);
        rst_n    = 1'b1;
        rd_we    = 1'b1;
        rd_addr  = 4'd4;
        rd_data  = 32'h55AA55AA;
        rs1_addr = 4'd4;
        #1;
        check("no_bypass_in_reset", rs1_data, 32'h0F0F0F0F);
        tick();
        rst_n = 1'b0;
        rd_we = 1'b0;
        #1;
        check("x4_after_collision", rs1_data, 32'h0);

        // sweep all writable registers, read back with both ports
        for (int i = 1; i < 16; i++) begin
            write_reg(4'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 1; i < 16; i++) begin
            rs1_addr = 4'(i);
            rs2_addr = 4'(16 - i);
            #1;
            check("sweep_rs1", rs1_data, 32'(i) * 32'h01010101);
            check("sweep_rs2", rs2_data, 32'(16 - i) * 32'h01010101);
        end
        rs1_addr = 4'd0;
        rs2_addr = 4'd0;
        #1;
        check("sweep_x0_rs1", rs1_data, 32'h0);
        check("sweep_x0_rs2", rs2_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
